// File: rtl/sram_ppm_uart_tx.sv
// sram_ppm_uart_tx: streams a decoded RGB frame from SRAM over UART as a
// binary PPM (P6) file: a fixed 15-byte header, then each 16-bit SRAM word
// as high byte followed by low byte.
//
// state    | meaning
// S_IDLE   | waiting for Start, Busy low
// S_HDR    | queueing header ROM byte hdr_idx
// S_RD_REQ | SRAM address for word_idx presented
// S_RD_W1  | SRAM read latency wait
// S_RD_CAP | capture read data into word_buf
// S_TX_HI  | queueing high byte of word_buf
// S_TX_LO  | queueing low byte, then next word or flush
// S_FLUSH  | waiting for last frame to leave the wire, then Done
module sram_ppm_uart_tx #(
  parameter int CLK_PER_BIT = 434,
  parameter int NUM_WORDS   = 115200,
  parameter bit ZERO_SUB    = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [17:0] Base_address,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        UART_TX,
  output logic        Busy,
  output logic        Done
);

  localparam int BAUD_W = $clog2(CLK_PER_BIT);
  localparam int WIDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD_REQ,
    S_RD_W1,
    S_RD_CAP,
    S_TX_HI,
    S_TX_LO,
    S_FLUSH
  } state_t;

  state_t            state;
  logic [3:0]        hdr_idx;
  logic [WIDX_W-1:0] word_idx;
  logic [15:0]       word_buf;
  logic [17:0]       base_addr;

  logic              tx_active;
  logic [3:0]        tx_bit;
  logic [BAUD_W-1:0] tx_baud;
  logic [8:0]        tx_shift;
  logic              tx_ready;
  logic              tx_load;
  logic [7:0]        tx_data;

  // "P6\n320 240\n255\n"
  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    hdr_byte = 8'h50;
      4'd1:    hdr_byte = 8'h36;
      4'd2:    hdr_byte = 8'h0A;
      4'd3:    hdr_byte = 8'h33;
      4'd4:    hdr_byte = 8'h32;
      4'd5:    hdr_byte = 8'h30;
      4'd6:    hdr_byte = 8'h20;
      4'd7:    hdr_byte = 8'h32;
      4'd8:    hdr_byte = 8'h34;
      4'd9:    hdr_byte = 8'h30;
      4'd10:   hdr_byte = 8'h0A;
      4'd11:   hdr_byte = 8'h32;
      4'd12:   hdr_byte = 8'h35;
      4'd13:   hdr_byte = 8'h35;
      4'd14:   hdr_byte = 8'h0A;
      default: hdr_byte = 8'h00;
    endcase
  endfunction

  // Pixel bytes of zero are nudged to one so the host never sees a NUL
  function automatic logic [7:0] zsub(input logic [7:0] b);
    zsub = (ZERO_SUB && (b == 8'h00)) ? 8'h01 : b;
  endfunction

  // Ready while idle, and in the final stop-bit cycle so frames chain gap-free
  assign tx_ready  = !tx_active || ((tx_bit == 4'd9) && (tx_baud == '0));
  assign SRAM_we_n = 1'b1;

  // Byte source for the serializer, chosen by the current FSM state
  always_comb begin
    tx_load = 1'b0;
    tx_data = 8'h00;
    case (state)
      S_HDR: begin
        tx_load = 1'b1;
        tx_data = hdr_byte(hdr_idx);
      end
      S_TX_HI: begin
        tx_load = 1'b1;
        tx_data = zsub(word_buf[15:8]);
      end
      S_TX_LO: begin
        tx_load = 1'b1;
        tx_data = zsub(word_buf[7:0]);
      end
      default: ;
    endcase
  end

  // Serializer: start bit, data LSB first, stop bit, each held CLK_PER_BIT cycles
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tx_active <= 1'b0;
      tx_bit    <= '0;
      tx_baud   <= '0;
      tx_shift  <= '1;
      UART_TX   <= 1'b1;
    end else if (tx_load && tx_ready) begin
      tx_active <= 1'b1;
      tx_bit    <= '0;
      tx_baud   <= BAUD_LAST;
      tx_shift  <= {1'b1, tx_data};
      UART_TX   <= 1'b0;
    end else if (tx_active) begin
      if (tx_baud == '0) begin
        if (tx_bit == 4'd9) begin
          tx_active <= 1'b0;
        end else begin
          tx_bit   <= tx_bit + 4'd1;
          tx_baud  <= BAUD_LAST;
          UART_TX  <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
        end
      end else begin
        tx_baud <= tx_baud - 1'b1;
      end
    end
  end

  // Main sequencer: header, then read/send each word, then flush and Done.
  // The address is set on entry to S_RD_REQ so the word is valid in S_RD_CAP.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= S_IDLE;
      hdr_idx      <= '0;
      word_idx     <= '0;
      word_buf     <= '0;
      base_addr    <= '0;
      SRAM_address <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            base_addr <= Base_address;
            hdr_idx   <= '0;
            word_idx  <= '0;
            Busy      <= 1'b1;
            state     <= S_HDR;
          end
        end
        S_HDR: begin
          if (tx_ready) begin
            if (hdr_idx == 4'd14) begin
              SRAM_address <= base_addr;
              state        <= S_RD_REQ;
            end else begin
              hdr_idx <= hdr_idx + 4'd1;
            end
          end
        end
        S_RD_REQ: state <= S_RD_W1;
        S_RD_W1:  state <= S_RD_CAP;
        S_RD_CAP: begin
          word_buf <= SRAM_read_data;
          state    <= S_TX_HI;
        end
        S_TX_HI: begin
          if (tx_ready) state <= S_TX_LO;
        end
        S_TX_LO: begin
          if (tx_ready) begin
            if (word_idx == WIDX_LAST) begin
              state <= S_FLUSH;
            end else begin
              word_idx     <= word_idx + 1'b1;
              SRAM_address <= SRAM_address + 18'd1;
              state        <= S_RD_REQ;
            end
          end
        end
        S_FLUSH: begin
          if (!tx_active) begin
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ppm_uart_tx.sv
// tb_sram_ppm_uart_tx: randomized and directed bench for the PPM UART dumper.
// A cycle-level model derives UART_TX/Busy/Done from the byte stream the
// frame must produce; a UART decoder recovers bytes for literal checks.
module tb_sram_ppm_uart_tx;

  localparam int CPB    = 4;
  localparam int NW     = 2;
  localparam int NBYTES = 15 + 2 * NW;
  localparam int L      = NBYTES * 10 * CPB;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [17:0] Base_address;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        UART_TX;
  logic        Busy;
  logic        Done;

  sram_ppm_uart_tx #(.CLK_PER_BIT(CPB), .NUM_WORDS(NW), .ZERO_SUB(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Base_address(Base_address),
    .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n),
    .SRAM_read_data(SRAM_read_data), .UART_TX(UART_TX), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  // SRAM: data appears two cycles after its address
  logic [15:0] mem [0:262143];
  logic [15:0] rd_d1, rd_d2;
  always @(posedge Clock) begin
    rd_d1 <= mem[SRAM_address];
    rd_d2 <= rd_d1;
  end
  assign SRAM_read_data = rd_d2;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [7:0] hdr_lit [15] = '{8'h50, 8'h36, 8'h0A, 8'h33, 8'h32, 8'h30, 8'h20,
                               8'h32, 8'h34, 8'h30, 8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A};

  function automatic logic [7:0] zs(input logic [7:0] b);
    return (b == 8'h00) ? 8'h01 : b;
  endfunction

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  bit          chk_en = 0;
  bit          dump_valid = 0;
  int          dump_s = 0;
  logic [17:0] dump_base;
  logic [7:0]  exp_q [$];
  bit          addr_known = 0;
  logic [17:0] exp_addr;

  task automatic build_stream(input logic [17:0] base);
    logic [17:0] a;
    exp_q.delete();
    for (int i = 0; i < 15; i++) exp_q.push_back(hdr_lit[i]);
    for (int w = 0; w < NW; w++) begin
      a = base + 18'(w);
      exp_q.push_back(zs(mem[a][15:8]));
      exp_q.push_back(zs(mem[a][7:0]));
    end
  endtask

  // Compare DUT to the model each cycle, then apply this cycle's inputs
  always @(negedge Clock) begin : model_cmp
    logic exp_tx, exp_busy, exp_done;
    int k, fr, bi;
    exp_busy = dump_valid && (cyc >= dump_s + 1) && (cyc <= dump_s + L + 2);
    exp_done = dump_valid && (cyc == dump_s + L + 3);
    exp_tx   = 1'b1;
    if (dump_valid) begin
      k = cyc - dump_s - 2;
      if (k >= 0 && k < L) begin
        fr = k / (10 * CPB);
        bi = (k / CPB) % 10;
        if (bi == 0)      exp_tx = 1'b0;
        else if (bi == 9) exp_tx = 1'b1;
        else              exp_tx = exp_q[fr][bi-1];
      end
    end
    if (chk_en) begin
      check("uart_tx", UART_TX, exp_tx);
      check("busy", Busy, exp_busy);
      check("done", Done, exp_done);
      check("we_n", SRAM_we_n, 1'b1);
      if (addr_known && !exp_busy) check("idle_addr", SRAM_address, exp_addr);
    end
    if (Reset) begin
      chk_en     = 1;
      dump_valid = 0;
      addr_known = 1;
      exp_addr   = '0;
    end else if (chk_en) begin
      if (exp_done) begin
        addr_known = 1;
        exp_addr   = dump_base + 18'(NW - 1);
      end
      if (Start && !exp_busy) begin
        dump_valid = 1;
        dump_s     = cyc;
        dump_base  = Base_address;
        addr_known = 0;
        build_stream(Base_address);
      end
    end
    cyc++;
  end

  // ---------------- UART decoder ----------------
  logic [7:0] rx_q [$];
  bit         rx_busy = 0;
  int         rx_cnt;
  logic [7:0] rx_sh;
  always @(negedge Clock) begin : rx_dec
    int j;
    if (Reset) begin
      rx_busy = 0;
    end else if (!rx_busy) begin
      if (UART_TX === 1'b0) begin
        rx_busy = 1;
        rx_cnt  = 1;
      end
    end else begin
      if (rx_cnt % CPB == CPB / 2) begin
        j = rx_cnt / CPB;
        if (j >= 1 && j <= 8) rx_sh[j-1] = UART_TX;
        if (j == 9) begin
          check("rx_stop", UART_TX, 1'b1);
          rx_q.push_back(rx_sh);
          rx_busy = 0;
        end
      end
      rx_cnt++;
    end
  end

  // Log of address changes, for the wrap-around sequence check
  logic [17:0] addr_log [$];
  logic [17:0] addr_prev;
  always @(negedge Clock) begin
    if (SRAM_address !== addr_prev) addr_log.push_back(SRAM_address);
    addr_prev = SRAM_address;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_start(input logic [17:0] base);
    Base_address = base;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < L + 100) begin
      @(negedge Clock);
      n++;
      if (Done === 1'b1) break;
    end
    check("done_seen", Done, 1'b1);
    tick();
  endtask

  task automatic check_rx_vs_model(input string tag);
    check({tag, "_rx_len"}, rx_q.size(), NBYTES);
    for (int i = 0; i < NBYTES && i < rx_q.size(); i++)
      check({tag, "_rx_byte"}, rx_q[i], exp_q[i]);
  endtask

  initial begin
    int n, ndone, rst_at, dup_at;
    bit do_rst;
    logic [17:0] base;

    for (int i = 0; i < 262144; i++) mem[i] = 16'($urandom);
    Reset = 1'b1;
    Start = 1'b0;
    Base_address = '0;

    // T1: reset only, then idle
    repeat (2) tick();
    Reset = 1'b0;
    repeat (100) tick();
    check("t1_tx", UART_TX, 1'b1);
    check("t1_busy", Busy, 1'b0);

    // T2: header framing and plain data
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    rx_q.delete();
    pulse_start(18'h0);
    check("model_len", exp_q.size(), 19);
    check("model_b0", exp_q[0], 8'h50);
    check("model_b14", exp_q[14], 8'h0A);
    check("model_b15", exp_q[15], 8'h12);
    check("model_b18", exp_q[18], 8'hCD);
    wait_done(n);
    check("t2_done_min", (n >= 19 * 40) ? 1 : 0, 1);
    check("t2_done_max", (n <= 19 * 40 + 4) ? 1 : 0, 1);
    check("t2_rx_len", rx_q.size(), 19);
    if (rx_q.size() == 19) begin
      for (int i = 0; i < 15; i++) check("t2_hdr", rx_q[i], hdr_lit[i]);
      check("t2_d0", rx_q[15], 8'h12);
      check("t2_d1", rx_q[16], 8'h34);
      check("t2_d2", rx_q[17], 8'hAB);
      check("t2_d3", rx_q[18], 8'hCD);
    end
    check("t2_addr", SRAM_address, 18'h1);

    // T3: zero substitution
    mem[5] = 16'h00FF;
    mem[6] = 16'h0000;
    rx_q.delete();
    pulse_start(18'd5);
    wait_done(n);
    check("t3_rx_len", rx_q.size(), 19);
    if (rx_q.size() == 19) begin
      check("t3_d0", rx_q[15], 8'h01);
      check("t3_d1", rx_q[16], 8'hFF);
      check("t3_d2", rx_q[17], 8'h01);
      check("t3_d3", rx_q[18], 8'h01);
    end

    // T4: address wrap
    mem[18'h3FFFF] = 16'hA5C3;
    mem[0] = 16'h5A00;
    rx_q.delete();
    addr_log.delete();
    pulse_start(18'h3FFFF);
    wait_done(n);
    check("t4_addr_seq_len", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      check("t4_addr0", addr_log[0], 18'h3FFFF);
      check("t4_addr1", addr_log[1], 18'h00000);
    end
    check("t4_rx_len", rx_q.size(), 19);
    if (rx_q.size() == 19) begin
      check("t4_d0", rx_q[15], 8'hA5);
      check("t4_d1", rx_q[16], 8'hC3);
      check("t4_d2", rx_q[17], 8'h5A);
      check("t4_d3", rx_q[18], 8'h01);
    end

    // T5: Start while Busy is ignored
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    rx_q.delete();
    pulse_start(18'h0);
    ndone = 0;
    for (int c = 1; c < L + 60; c++) begin
      Start = (c == 60);
      Base_address = 18'd100;
      @(negedge Clock);
      if (Done === 1'b1) ndone++;
      tick();
    end
    Start = 1'b0;
    check("t5_ndone", ndone, 1);
    check("t5_rx_len", rx_q.size(), 19);
    if (rx_q.size() == 19) begin
      check("t5_d0", rx_q[15], 8'h12);
      check("t5_d3", rx_q[18], 8'hCD);
    end

    // T6: reset in the middle of a data byte, then a clean restart
    pulse_start(18'h0);
    repeat (619) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge Clock);
    check("t6_tx_after_rst", UART_TX, 1'b1);
    check("t6_busy_after_rst", Busy, 1'b0);
    tick();
    rx_q.delete();
    pulse_start(18'h0);
    wait_done(n);
    check("t6_rx_len", rx_q.size(), 19);
    if (rx_q.size() > 0) check("t6_first", rx_q[0], 8'h50);

    // T7: Reset and Start together, Reset wins
    Reset = 1'b1;
    Start = 1'b1;
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    repeat (3) tick();
    check("t7_busy", Busy, 1'b0);

    // Randomized dumps with stray Starts, random data and occasional resets
    for (int it = 0; it < 10; it++) begin
      base = 18'($urandom);
      for (int w = 0; w < NW; w++)
        mem[base + 18'(w)] = {(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom)),
                              (($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom))};
      do_rst = ($urandom_range(0, 3) == 0);
      rst_at = $urandom_range(20, L - 20);
      dup_at = do_rst ? 0 : $urandom_range(3, L - 20);
      rx_q.delete();
      pulse_start(base);
      ndone = 0;
      for (int c = 1; c < L + 40; c++) begin
        Start = (c == dup_at);
        Reset = do_rst && (c == rst_at);
        Base_address = 18'($urandom);
        @(negedge Clock);
        if (Done === 1'b1) ndone++;
        tick();
      end
      Start = 1'b0;
      Reset = 1'b0;
      if (do_rst) begin
        check("rnd_ndone_rst", ndone, 0);
      end else begin
        check("rnd_ndone", ndone, 1);
        check_rx_vs_model("rnd");
      end
    end

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
